// File: rtl/param_bus_datapath_if.sv
// Bus-side signals of param_bus_datapath: op request/handshake, status,
// observation outputs and the external register load/inspect port.
interface param_bus_datapath_if #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
);
   localparam int IDX_W = $clog2(NUM_REGS);

   logic              start;
   logic [2:0]        op;
   logic [IDX_W-1:0]  ra;
   logic [IDX_W-1:0]  rb;
   logic [IDX_W-1:0]  rd;
   logic              ext_we;
   logic [IDX_W-1:0]  ext_idx;
   logic [DATA_W-1:0] ext_wdata;
   logic [DATA_W-1:0] ext_rdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic [DATA_W-1:0] bus_q;

   modport master (
      output start, op, ra, rb, rd, ext_we, ext_idx, ext_wdata,
      input  ext_rdata, busy, done, err, hi_q, lo_q, bus_q
   );

   modport slave (
      input  start, op, ra, rb, rd, ext_we, ext_idx, ext_wdata,
      output ext_rdata, busy, done, err, hi_q, lo_q, bus_q
   );
endinterface

// File: rtl/param_bus_datapath.sv
// Single-bus datapath: register file, Y, Z(hi/lo), HI, LO and an ALU, stepped
// through fixed T-states by an internal controller, one op per start/done.
module param_bus_datapath #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input logic                 clk,
   input logic                 clr,
   param_bus_datapath_if.slave bus_if
);
   localparam int IDX_W = $clog2(NUM_REGS);

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_MUL = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TA,
      S_TB,
      S_WLO,
      S_WHI,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [IDX_W-1:0]    ra_q, ra_d;
   logic [IDX_W-1:0]    rb_q, rb_d;
   logic [IDX_W-1:0]    rd_q, rd_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   y_q, y_d;
   logic [2*DATA_W-1:0] z_q, z_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [DATA_W-1:0]   bus_val;
   logic [2*DATA_W-1:0] alu_res;

   always_comb begin
      bus_val = '0;
      case (state_q)
         S_TA:    bus_val = regs_q[ra_q];
         S_TB:    bus_val = regs_q[rb_q];
         S_WLO:   bus_val = z_q[DATA_W-1:0];
         S_WHI:   bus_val = z_q[2*DATA_W-1:DATA_W];
         default: bus_val = '0;
      endcase
   end

   // Y holds operand A; the bus carries operand B during T_B.
   always_comb begin
      alu_res = '0;
      case (op_q)
         OP_AND:  alu_res = {{DATA_W{1'b0}}, y_q & bus_val};
         OP_OR:   alu_res = {{DATA_W{1'b0}}, y_q | bus_val};
         OP_ADD:  alu_res = {{DATA_W{1'b0}}, y_q + bus_val};
         OP_SUB:  alu_res = {{DATA_W{1'b0}}, y_q - bus_val};
         OP_MUL:  alu_res = {{DATA_W{1'b0}}, y_q} * {{DATA_W{1'b0}}, bus_val};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rd_d    = rd_q;
      err_d   = err_q;
      y_d     = y_q;
      z_d     = z_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      regs_d  = regs_q;
      case (state_q)
         S_IDLE: begin
            // External write lands before T_A reads, so a same-cycle op sees it.
            if (bus_if.ext_we) regs_d[bus_if.ext_idx] = bus_if.ext_wdata;
            if (bus_if.start) begin
               op_d    = bus_if.op;
               ra_d    = bus_if.ra;
               rb_d    = bus_if.rb;
               rd_d    = bus_if.rd;
               err_d   = (bus_if.op > OP_MUL);
               state_d = (bus_if.op > OP_MUL) ? S_DONE : S_TA;
            end
         end
         S_TA: begin
            y_d     = bus_val;
            state_d = S_TB;
         end
         S_TB: begin
            z_d     = alu_res;
            state_d = S_WLO;
         end
         S_WLO: begin
            if (op_q == OP_MUL) begin
               lo_d    = bus_val;
               state_d = S_WHI;
            end else begin
               regs_d[rd_q] = bus_val;
               state_d      = S_DONE;
            end
         end
         S_WHI: begin
            hi_d    = bus_val;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
         y_q     <= '0;
         z_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         regs_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         y_q     <= y_d;
         z_q     <= z_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         regs_q  <= regs_d;
      end
   end

   assign bus_if.ext_rdata = regs_q[bus_if.ext_idx];
   assign bus_if.busy      = (state_q != S_IDLE);
   assign bus_if.done      = (state_q == S_DONE);
   assign bus_if.err       = (state_q == S_DONE) && err_q;
   assign bus_if.hi_q      = hi_q;
   assign bus_if.lo_q      = lo_q;
   assign bus_if.bus_q     = bus_val;
endmodule

// File: tb/tb_param_bus_datapath.sv
// Self-checking bench for param_bus_datapath against a behavioural register-file model.
module tb_param_bus_datapath;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 16;
   localparam int IDX_W    = 4;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   param_bus_datapath_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut_if ();
   param_bus_datapath #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
      .clk    (clk),
      .clr    (clr),
      .bus_if (dut_if)
   );

   int n_vec = 0;
   int n_mis = 0;

   logic [DATA_W-1:0] model_regs [NUM_REGS];
   logic [DATA_W-1:0] model_hi;
   logic [DATA_W-1:0] model_lo;

   task automatic model_reset();
      for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
      model_hi = '0;
      model_lo = '0;
   endtask

   task automatic model_op(input logic [2:0] op, input logic [IDX_W-1:0] ra,
                           input logic [IDX_W-1:0] rb, input logic [IDX_W-1:0] rd);
      logic [DATA_W-1:0]   a, b;
      logic [2*DATA_W-1:0] p;
      a = model_regs[ra];
      b = model_regs[rb];
      case (op)
         3'd0: model_regs[rd] = a & b;
         3'd1: model_regs[rd] = a | b;
         3'd2: model_regs[rd] = a + b;
         3'd3: model_regs[rd] = a - b;
         3'd4: begin
            p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
            model_hi = p[2*DATA_W-1:DATA_W];
            model_lo = p[DATA_W-1:0];
         end
         default: ;
      endcase
   endtask

   function automatic int exp_latency(input logic [2:0] op);
      if (op == 3'd4) return 5;
      if (op > 3'd4) return 1;
      return 4;
   endfunction

   task automatic drive_idle();
      dut_if.start     = 1'b0;
      dut_if.op        = '0;
      dut_if.ra        = '0;
      dut_if.rb        = '0;
      dut_if.rd        = '0;
      dut_if.ext_we    = 1'b0;
      dut_if.ext_idx   = '0;
      dut_if.ext_wdata = '0;
   endtask

   task automatic ext_write(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] val);
      @(negedge clk);
      dut_if.ext_we    = 1'b1;
      dut_if.ext_idx   = idx;
      dut_if.ext_wdata = val;
      @(negedge clk);
      dut_if.ext_we = 1'b0;
      model_regs[idx] = val;
   endtask

   task automatic read_reg(input logic [IDX_W-1:0] idx, output logic [DATA_W-1:0] val);
      dut_if.ext_idx = idx;
      #1;
      val = dut_if.ext_rdata;
   endtask

   // Issues one op; optional same-cycle ext write and mid-op disturbance. lat=0 means timeout.
   task automatic run_op(input logic [2:0] op, input logic [IDX_W-1:0] ra,
                         input logic [IDX_W-1:0] rb, input logic [IDX_W-1:0] rd,
                         input bit disturb, input bit co_write,
                         input logic [IDX_W-1:0] cw_idx, input logic [DATA_W-1:0] cw_val,
                         output int lat, output bit err_seen,
                         output logic [DATA_W-1:0] bus_a, output int busy_bad);
      lat      = 0;
      err_seen = 1'b0;
      bus_a    = '0;
      busy_bad = 0;
      @(negedge clk);
      dut_if.start = 1'b1;
      dut_if.op    = op;
      dut_if.ra    = ra;
      dut_if.rb    = rb;
      dut_if.rd    = rd;
      if (co_write) begin
         dut_if.ext_we    = 1'b1;
         dut_if.ext_idx   = cw_idx;
         dut_if.ext_wdata = cw_val;
         model_regs[cw_idx] = cw_val;
      end
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) begin
            dut_if.start  = 1'b0;
            dut_if.ext_we = 1'b0;
            dut_if.op     = 3'($urandom);
            dut_if.ra     = IDX_W'($urandom);
            dut_if.rb     = IDX_W'($urandom);
            dut_if.rd     = IDX_W'($urandom);
            bus_a         = dut_if.bus_q;
         end
         if (!dut_if.busy) busy_bad++;
         if (disturb && k == 2) begin
            dut_if.start     = 1'b1;
            dut_if.op        = 3'd2;
            dut_if.ext_we    = 1'b1;
            dut_if.ext_idx   = rd;
            dut_if.ext_wdata = $urandom;
         end
         if (disturb && k == 3) begin
            dut_if.start  = 1'b0;
            dut_if.ext_we = 1'b0;
         end
         if (dut_if.done) begin
            lat      = k;
            err_seen = dut_if.err;
            break;
         end
      end
      dut_if.start  = 1'b0;
      dut_if.ext_we = 1'b0;
      @(negedge clk);
      model_op(op, ra, rb, rd);
   endtask

   task automatic test_reset();
      logic [DATA_W-1:0] v;
      ext_write(4'd5, 32'hFFFF_FFFF);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_reset();
      read_reg(4'd5, v);
      n_vec++;
      if (v !== 32'h0) begin n_mis++; $display("[TB] FAIL reset_r5: got %h expected 0", v); end
      n_vec++;
      if (dut_if.hi_q !== 32'h0 || dut_if.lo_q !== 32'h0) begin
         n_mis++; $display("[TB] FAIL reset_hilo: got hi=%h lo=%h expected 0", dut_if.hi_q, dut_if.lo_q);
      end
      n_vec++;
      if ({dut_if.busy, dut_if.done, dut_if.err} !== 3'b000) begin
         n_mis++; $display("[TB] FAIL reset_status: got busy/done/err=%b expected 000",
                           {dut_if.busy, dut_if.done, dut_if.err});
      end
      n_vec++;
      if (dut_if.bus_q !== 32'h0) begin n_mis++; $display("[TB] FAIL reset_bus: got %h expected 0", dut_if.bus_q); end
   endtask

   task automatic test_add_wrap();
      int lat, busy_bad;
      bit e;
      logic [DATA_W-1:0] ba, v;
      ext_write(4'd1, 32'hFFFF_FFFF);
      ext_write(4'd2, 32'd2);
      run_op(3'd2, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, '0, '0, lat, e, ba, busy_bad);
      n_vec++;
      if (lat !== 4) begin n_mis++; $display("[TB] FAIL add_latency: got %0d expected 4", lat); end
      n_vec++;
      if (ba !== 32'hFFFF_FFFF) begin n_mis++; $display("[TB] FAIL add_bus_ta: got %h expected ffffffff", ba); end
      n_vec++;
      if (busy_bad !== 0) begin n_mis++; $display("[TB] FAIL add_busy: got %0d idle cycles expected 0", busy_bad); end
      read_reg(4'd3, v);
      n_vec++;
      if (v !== 32'd1) begin n_mis++; $display("[TB] FAIL add_wrap_r3: got %h expected 1", v); end
      n_vec++;
      if (dut_if.busy !== 1'b0 || dut_if.done !== 1'b0) begin
         n_mis++; $display("[TB] FAIL add_after_done: got busy=%b done=%b expected 0 0", dut_if.busy, dut_if.done);
      end
   endtask

   task automatic test_mul();
      int lat, busy_bad, diffs;
      bit e;
      logic [DATA_W-1:0] ba, v;
      ext_write(4'd4, 32'h0001_0000);
      ext_write(4'd6, 32'h0003_0000);
      run_op(3'd4, 4'd4, 4'd6, 4'd9, 1'b0, 1'b0, '0, '0, lat, e, ba, busy_bad);
      n_vec++;
      if (lat !== 5) begin n_mis++; $display("[TB] FAIL mul_latency: got %0d expected 5", lat); end
      n_vec++;
      if (dut_if.hi_q !== 32'd3 || dut_if.lo_q !== 32'd0) begin
         n_mis++; $display("[TB] FAIL mul_hilo: got hi=%h lo=%h expected hi=3 lo=0", dut_if.hi_q, dut_if.lo_q);
      end
      diffs = 0;
      for (int i = 0; i < NUM_REGS; i++) begin
         read_reg(IDX_W'(i), v);
         if (v !== model_regs[i]) diffs++;
      end
      n_vec++;
      if (diffs !== 0) begin n_mis++; $display("[TB] FAIL mul_regs_untouched: got %0d changed expected 0", diffs); end
   endtask

   task automatic test_alias();
      int lat, busy_bad;
      bit e;
      logic [DATA_W-1:0] ba, v;
      ext_write(4'd7, 32'd10);
      run_op(3'd3, 4'd7, 4'd7, 4'd7, 1'b0, 1'b0, '0, '0, lat, e, ba, busy_bad);
      read_reg(4'd7, v);
      n_vec++;
      if (v !== 32'd0) begin n_mis++; $display("[TB] FAIL alias_sub_r7: got %h expected 0", v); end
      ext_write(4'd8, 32'h0000_F0F0);
      run_op(3'd0, 4'd7, 4'd8, 4'd8, 1'b0, 1'b0, '0, '0, lat, e, ba, busy_bad);
      read_reg(4'd8, v);
      n_vec++;
      if (v !== 32'd0) begin n_mis++; $display("[TB] FAIL alias_and_r8: got %h expected 0", v); end
   endtask

   task automatic test_illegal_busy();
      int lat, busy_bad, diffs, late_busy;
      bit e;
      logic [DATA_W-1:0] ba, v;
      logic [DATA_W-1:0] hi0, lo0;
      hi0 = model_hi;
      lo0 = model_lo;
      run_op(3'd6, 4'd1, 4'd2, 4'd1, 1'b0, 1'b0, '0, '0, lat, e, ba, busy_bad);
      n_vec++;
      if (lat !== 1) begin n_mis++; $display("[TB] FAIL illegal_latency: got %0d expected 1", lat); end
      n_vec++;
      if (e !== 1'b1) begin n_mis++; $display("[TB] FAIL illegal_err: got %b expected 1", e); end
      n_vec++;
      if (dut_if.hi_q !== hi0 || dut_if.lo_q !== lo0) begin
         n_mis++; $display("[TB] FAIL illegal_hilo: got hi=%h lo=%h expected hi=%h lo=%h", dut_if.hi_q, dut_if.lo_q, hi0, lo0);
      end
      run_op(3'd2, 4'd1, 4'd2, 4'd10, 1'b1, 1'b0, '0, '0, lat, e, ba, busy_bad);
      n_vec++;
      if (lat !== 4 || e !== 1'b0) begin n_mis++; $display("[TB] FAIL disturbed_add: got lat=%0d err=%b expected 4 0", lat, e); end
      late_busy = 0;
      for (int i = 0; i < 3; i++) begin
         if (dut_if.busy) late_busy++;
         @(negedge clk);
      end
      n_vec++;
      if (late_busy !== 0) begin n_mis++; $display("[TB] FAIL start_not_queued: got %0d busy cycles expected 0", late_busy); end
      diffs = 0;
      for (int i = 0; i < NUM_REGS; i++) begin
         read_reg(IDX_W'(i), v);
         if (v !== model_regs[i]) diffs++;
      end
      n_vec++;
      if (diffs !== 0) begin n_mis++; $display("[TB] FAIL busy_ext_ignored: got %0d reg diffs expected 0", diffs); end
   endtask

   task automatic test_back_to_back();
      int done_at [2];
      int nd, busy_gap;
      logic [DATA_W-1:0] v;
      ext_write(4'd11, 32'h1234_0000);
      ext_write(4'd12, 32'h0000_5678);
      nd = 0;
      busy_gap = -1;
      done_at[0] = 0;
      done_at[1] = 0;
      @(negedge clk);
      dut_if.start = 1'b1;
      dut_if.op    = 3'd1;
      dut_if.ra    = 4'd11;
      dut_if.rb    = 4'd12;
      dut_if.rd    = 4'd13;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 5) busy_gap = int'(dut_if.busy);
         if (dut_if.done && nd < 2) begin done_at[nd] = k; nd++; end
         if (k == 6) dut_if.start = 1'b0;
      end
      dut_if.start = 1'b0;
      model_op(3'd1, 4'd11, 4'd12, 4'd13);
      model_op(3'd1, 4'd11, 4'd12, 4'd13);
      n_vec++;
      if (done_at[0] !== 4 || done_at[1] !== 9) begin
         n_mis++; $display("[TB] FAIL b2b_done_cycles: got %0d,%0d expected 4,9", done_at[0], done_at[1]);
      end
      n_vec++;
      if (busy_gap !== 0) begin n_mis++; $display("[TB] FAIL b2b_idle_gap: got busy=%0d expected 0", busy_gap); end
      read_reg(4'd13, v);
      n_vec++;
      if (v !== model_regs[13]) begin n_mis++; $display("[TB] FAIL b2b_result: got %h expected %h", v, model_regs[13]); end
   endtask

   task automatic test_same_cycle_write();
      int lat, busy_bad;
      bit e;
      logic [DATA_W-1:0] ba, v, nv;
      ext_write(4'd10, 32'd100);
      ext_write(4'd11, 32'd23);
      nv = $urandom;
      run_op(3'd2, 4'd10, 4'd11, 4'd12, 1'b0, 1'b1, 4'd10, nv, lat, e, ba, busy_bad);
      read_reg(4'd12, v);
      n_vec++;
      if (v !== nv + 32'd23) begin n_mis++; $display("[TB] FAIL same_cycle_write: got %h expected %h", v, nv + 32'd23); end
   endtask

   task automatic test_abort();
      int dones, lat, busy_bad;
      bit e;
      logic [DATA_W-1:0] ba, v;
      ext_write(4'd1, 32'd40);
      ext_write(4'd2, 32'd2);
      @(negedge clk);
      dut_if.start = 1'b1;
      dut_if.op    = 3'd2;
      dut_if.ra    = 4'd1;
      dut_if.rb    = 4'd2;
      dut_if.rd    = 4'd13;
      @(negedge clk);
      dut_if.start = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_reset();
      dones = 0;
      for (int k = 0; k < 8; k++) begin
         if (dut_if.done) dones++;
         @(negedge clk);
      end
      n_vec++;
      if (dones !== 0) begin n_mis++; $display("[TB] FAIL abort_no_done: got %0d done pulses expected 0", dones); end
      read_reg(4'd13, v);
      n_vec++;
      if (v !== 32'd0) begin n_mis++; $display("[TB] FAIL abort_rd: got %h expected 0", v); end
      ext_write(4'd1, 32'd5);
      ext_write(4'd2, 32'd6);
      run_op(3'd2, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, '0, '0, lat, e, ba, busy_bad);
      read_reg(4'd3, v);
      n_vec++;
      if (lat !== 4 || v !== 32'd11) begin n_mis++; $display("[TB] FAIL abort_next_op: got lat=%0d r3=%h expected 4 0000000b", lat, v); end
   endtask

   task automatic test_random();
      int lat, busy_bad;
      bit e;
      logic [DATA_W-1:0] ba, v;
      logic [2:0] op;
      logic [IDX_W-1:0] ra, rb, rd, ci;
      for (int it = 0; it < 40; it++) begin
         ext_write(IDX_W'($urandom), $urandom);
         ext_write(IDX_W'($urandom), (it % 3 == 0) ? 32'hFFFF_FFFF : $urandom);
         op = 3'($urandom_range(0, 7));
         ra = IDX_W'($urandom);
         rb = IDX_W'($urandom);
         rd = IDX_W'($urandom);
         ci = IDX_W'($urandom);
         run_op(op, ra, rb, rd, 1'($urandom), 1'($urandom), ci, $urandom, lat, e, ba, busy_bad);
         n_vec++;
         if (lat !== exp_latency(op) || e !== (op > 3'd4)) begin
            n_mis++; $display("[TB] FAIL rand_timing op=%0d: got lat=%0d err=%b expected %0d %b", op, lat, e, exp_latency(op), op > 3'd4);
         end
         read_reg(rd, v);
         n_vec++;
         if (v !== model_regs[rd]) begin n_mis++; $display("[TB] FAIL rand_rd op=%0d: got %h expected %h", op, v, model_regs[rd]); end
         n_vec++;
         if (dut_if.hi_q !== model_hi || dut_if.lo_q !== model_lo) begin
            n_mis++; $display("[TB] FAIL rand_hilo op=%0d: got %h_%h expected %h_%h", op, dut_if.hi_q, dut_if.lo_q, model_hi, model_lo);
         end
      end
   endtask

   initial begin
      drive_idle();
      clr = 1'b1;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      model_reset();
      test_reset();
      test_add_wrap();
      test_mul();
      test_alias();
      test_illegal_busy();
      test_back_to_back();
      test_same_cycle_write();
      test_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
